// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode encodings and default sizing shared by the LED pattern engine
package led_pattern_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_SPEED_W = 4;
  typedef enum logic [1:0] {
    MODE_RUN_L  = 2'd0,
    MODE_RUN_R  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides accepted ticks by (speed+1) and flags the advancing tick
module tick_prescaler
  import led_pattern_pkg::*;
#(
  parameter int SPEED_W = DEFAULT_SPEED_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_en,
  input  logic [SPEED_W-1:0] speed,
  input  logic               clear,
  output logic               adv
);
  logic [SPEED_W-1:0] r_count;
  // >= rather than == so a speed lowered below the current count advances on the next tick
  assign adv = tick_en & (r_count >= speed);
  // count accepted ticks, wrapping to zero on an advance or an explicit clear
  always_ff @(posedge clk or posedge reset)
    if (reset) r_count <= '0;
    else if (clear || adv) r_count <= '0;
    else if (tick_en) r_count <= r_count + 1'b1;
endmodule

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: tick-driven LED pattern generator with four selectable patterns
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SPEED_W = DEFAULT_SPEED_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               pause,
  input  logic [1:0]         mode,
  input  logic [SPEED_W-1:0] speed,
  output logic [WIDTH-1:0]   leds,
  output logic               step,
  output logic [1:0]         cur_mode
);
  mode_e             r_mode;
  logic [WIDTH-1:0]  r_leds;
  logic              r_step;
  logic              r_down;
  logic              r_drain;
  logic              w_mode_chg;
  logic              w_adv;
  logic [WIDTH-1:0]  w_start;
  logic [WIDTH-1:0]  w_next;
  logic              w_down_next;
  logic              w_drain_next;
  assign leds = r_leds;
  assign step = r_step;
  assign cur_mode = r_mode;
  // a pending mode change swallows any tick in the same cycle
  assign w_mode_chg = (mode != r_mode);
  assign w_start = (mode == MODE_RUN_R) ? {1'b1, {(WIDTH-1){1'b0}}} :
                   (mode == MODE_FILL)  ? '0 : WIDTH'(1);
  tick_prescaler #(.SPEED_W(SPEED_W)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .tick_en(tick & ~pause & ~w_mode_chg),
    .speed  (speed),
    .clear  (w_mode_chg),
    .adv    (w_adv)
  );
  // next pattern value, bounce direction and fill phase for one advance
  always_comb begin
    w_next = r_leds;
    w_down_next = r_down;
    w_drain_next = r_drain;
    case (r_mode)
      MODE_RUN_L: w_next = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
      MODE_RUN_R: w_next = {r_leds[0], r_leds[WIDTH-1:1]};
      MODE_BOUNCE: begin
        w_down_next = r_down ? ~r_leds[0] : r_leds[WIDTH-1];
        w_next = w_down_next ? r_leds >> 1 : r_leds << 1;
      end
      MODE_FILL: begin
        w_drain_next = r_drain ? (r_leds != '0) : (&r_leds);
        w_next = w_drain_next ? r_leds >> 1 : {r_leds[WIDTH-2:0], 1'b1};
      end
    endcase
  end
  // output and pattern state: reset, then mode change, then advance
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_mode <= MODE_RUN_L;
      r_leds <= WIDTH'(1);
      r_step <= 1'b0;
      r_down <= 1'b0;
      r_drain <= 1'b0;
    end else if (w_mode_chg) begin
      r_mode <= mode_e'(mode);
      r_leds <= w_start;
      r_step <= 1'b0;
      r_down <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      r_step <= w_adv;
      if (w_adv) begin
        r_leds <= w_next;
        r_down <= w_down_next;
        r_drain <= w_drain_next;
      end
    end
endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed self-checking bench for led_pattern_engine
module tb_led_pattern_engine;
  logic       clk = 1'b0;
  logic       reset, tick, pause;
  logic [1:0] mode;
  logic [3:0] speed;
  logic [7:0] leds;
  logic       step;
  logic [1:0] cur_mode;
  logic       reset4, tick4;
  logic [1:0] mode4;
  logic [3:0] leds4;
  logic       step4;
  logic [1:0] cur_mode4;
  int n_run = 0;
  int n_fail = 0;
  logic [7:0] e29[9]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [7:0] e30[16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                          8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
  logic [7:0] e31[16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                          8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
  logic [7:0] prev;

  always #5 clk = ~clk;

  led_pattern_engine #(.WIDTH(8), .SPEED_W(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause), .mode(mode), .speed(speed),
    .leds(leds), .step(step), .cur_mode(cur_mode)
  );

  led_pattern_engine #(.WIDTH(4), .SPEED_W(4)) dut4 (
    .clk(clk), .reset(reset4), .tick(tick4), .pause(1'b0), .mode(mode4), .speed(4'd0),
    .leds(leds4), .step(step4), .cur_mode(cur_mode4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tk();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset4 = 1'b1; tick = 1'b0; tick4 = 1'b0; pause = 1'b0;
    mode = 2'd0; speed = 4'd0; mode4 = 2'd2;
    @(negedge clk); @(negedge clk);
    chk("rst_leds", leds, 8'h01);
    chk("rst_mode", cur_mode, 2'd0);
    chk("rst_step", step, 1'b0);
    reset = 1'b0; reset4 = 1'b0;
    @(negedge clk);
    chk("post_rst_leds", leds, 8'h01);
    chk("w4_mode_chg", cur_mode4, 2'd2);
    chk("w4_start", leds4, 4'h1);
    // run left, every tick advances
    for (int i = 0; i < 9; i++) begin
      tk();
      chk($sformatf("runl_leds%0d", i), leds, e29[i]);
      chk($sformatf("runl_step%0d", i), step, 1'b1);
    end
    @(negedge clk);
    chk("runl_step_drop", step, 1'b0);
    // bounce
    mode = 2'd2;
    @(negedge clk);
    chk("bnc_mode", cur_mode, 2'd2);
    chk("bnc_start", leds, 8'h01);
    chk("bnc_chg_step", step, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tk();
      chk($sformatf("bnc_leds%0d", i), leds, e30[i]);
    end
    // fill/drain at half rate
    mode = 2'd3; speed = 4'd1;
    @(negedge clk);
    chk("fill_start", leds, 8'h00);
    chk("fill_mode", cur_mode, 2'd3);
    prev = 8'h00;
    for (int i = 0; i < 32; i++) begin
      tk();
      chk($sformatf("fill_step%0d", i), step, (i % 2 == 1) ? 1'b1 : 1'b0);
      chk($sformatf("fill_leds%0d", i), leds, (i % 2 == 1) ? e31[i/2] : prev);
      if (i % 2 == 1) prev = e31[i/2];
    end
    // pause holds everything
    mode = 2'd0; speed = 4'd0;
    @(negedge clk);
    chk("pz_start", leds, 8'h01);
    tk(); tk(); tk();
    chk("pz_pre", leds, 8'h08);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tk();
      chk($sformatf("pz_leds%0d", i), leds, 8'h08);
      chk($sformatf("pz_step%0d", i), step, 1'b0);
    end
    pause = 1'b0;
    tk();
    chk("pz_resume", leds, 8'h10);
    chk("pz_resume_step", step, 1'b1);
    tk();
    chk("mc_pre", leds, 8'h20);
    // mode change beats a simultaneous tick
    mode = 2'd1;
    tk();
    chk("mc_leds", leds, 8'h80);
    chk("mc_mode", cur_mode, 2'd1);
    chk("mc_step", step, 1'b0);
    tk();
    chk("mc_next", leds, 8'h40);
    // lowering speed below the current count advances on the next tick
    speed = 4'd3;
    tk(); tk();
    chk("spd_hold", leds, 8'h40);
    chk("spd_hold_step", step, 1'b0);
    speed = 4'd0;
    tk();
    chk("spd_adv", leds, 8'h20);
    chk("spd_adv_step", step, 1'b1);
    // mode change while paused
    pause = 1'b1; mode = 2'd2;
    @(negedge clk);
    chk("pmc_mode", cur_mode, 2'd2);
    chk("pmc_leds", leds, 8'h01);
    pause = 1'b0;
    // width-4 bounce then asynchronous reset mid-pass
    for (int i = 0; i < 4; i++) begin
      tick4 = 1'b1;
      @(negedge clk);
      tick4 = 1'b0;
    end
    chk("w4_bnc", leds4, 4'h4);
    #1 reset4 = 1'b1;
    #1;
    chk("w4_arst_leds", leds4, 4'h1);
    chk("w4_arst_mode", cur_mode4, 2'd0);
    chk("w4_arst_step", step4, 1'b0);
    @(negedge clk);
    reset4 = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
